// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use stall, taken-branch flush and halt-drain sequencing; PIPE_HAZARD_PERF_EN adds perf counters
module pipe_hazard_ctrl #(
  parameter int OP_W = 6,
  parameter logic [OP_W-1:0] HALT_OP = 6'h3f,
  parameter int RA_W = 5,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W = 32
) (
  input  logic             sysclk,
  input  logic             cpu_reset,
  input  logic             id_valid,
  input  logic [OP_W-1:0]  id_op,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [RA_W-1:0]  ex_rd,
  input  logic             ex_we,
  input  logic             ex_is_load,
  input  logic             ex_branch_taken,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  state_t state, state_n;
  logic [1:0] dcnt, dcnt_n;
  logic lu, hlt;
  assign lu = id_valid & ex_is_load & ex_we & (ex_rd != '0) &
              ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));
  assign hlt = id_valid & (id_op == HALT_OP);
  // state and drain counter register
  always_ff @(posedge sysclk)
    if (cpu_reset) begin
      state <= RUN;
      dcnt <= '0;
    end else begin
      state <= state_n;
      dcnt <= dcnt_n;
    end
  // next state and zero-latency pipeline controls; reset forces bubbles everywhere
  always_comb begin
    pc_we = 1'b0;
    ifid_we = 1'b0;
    ifid_flush = 1'b1;
    idex_flush = 1'b1;
    halted = 1'b0;
    state_n = state;
    dcnt_n = dcnt;
    if (!cpu_reset)
      case (state)
        RUN: begin
          pc_we = ex_branch_taken | ~(lu | hlt);
          ifid_we = ex_branch_taken | ~lu;
          ifid_flush = ex_branch_taken | (~lu & hlt);
          idex_flush = ex_branch_taken | lu;
          state_n = (~ex_branch_taken & ~lu & hlt) ? DRAIN : RUN;
          dcnt_n = '0;
        end
        DRAIN: begin
          dcnt_n = dcnt + 2'd1;
          state_n = (dcnt == 2'(DRAIN_CYCLES - 1)) ? HALTED : DRAIN;
        end
        default: halted = 1'b1;
      endcase
  end
`ifdef PIPE_HAZARD_PERF_EN
  // saturating counters, frozen once halted
  always_ff @(posedge sysclk)
    if (cpu_reset) begin
      cycle_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (state != HALTED) begin
      if (~&cycle_cnt) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (state == RUN && lu && !ex_branch_taken && ~&stall_cnt) stall_cnt <= stall_cnt + CNT_W'(1);
      if (state == RUN && ex_branch_taken && ~&flush_cnt) flush_cnt <= flush_cnt + CNT_W'(1);
    end
`else
  assign cycle_cnt = '0;
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of stall, flush, halt drain and reset behaviour
module tb_pipe_hazard_ctrl;
  logic sysclk = 1'b0;
  logic cpu_reset, id_valid, id_uses_rs, id_uses_rt, ex_we, ex_is_load, ex_branch_taken;
  logic [5:0] id_op;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic pc_we, ifid_we, ifid_flush, idex_flush, halted;
  logic [31:0] cycle_cnt, stall_cnt, flush_cnt;
  logic [4:0] obs;
  int vecs = 0;
  int errs = 0;
  int mode = 0;
  int dc = 0;
  logic [31:0] ec = 0, es = 0, ef = 0;

  pipe_hazard_ctrl dut (
    .sysclk(sysclk), .cpu_reset(cpu_reset), .id_valid(id_valid), .id_op(id_op),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_rd(ex_rd), .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_branch_taken(ex_branch_taken),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .halted(halted), .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 sysclk = ~sysclk;
  assign obs = {pc_we, ifid_we, ifid_flush, idex_flush, halted};

  task automatic chk(input string tag, input logic [4:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: {pc_we,ifid_we,ifid_flush,idex_flush,halted} observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag);
    logic [95:0] exp;
`ifdef PIPE_HAZARD_PERF_EN
    exp = {ec, es, ef};
`else
    exp = '0;
`endif
    vecs++;
    assert ({cycle_cnt, stall_cnt, flush_cnt} === exp) else begin
      errs++;
      $error("FAIL %s: {cycle,stall,flush} observed %0d/%0d/%0d expected %0d/%0d/%0d", tag,
             cycle_cnt, stall_cnt, flush_cnt, exp[95:64], exp[63:32], exp[31:0]);
    end
  endtask

  task automatic idle();
    id_valid = 1'b1; id_op = 6'h00; id_rs = 5'd1; id_rt = 5'd2;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_rd = 5'd0;
    ex_we = 1'b0; ex_is_load = 1'b0; ex_branch_taken = 1'b0;
  endtask

  task automatic rnd();
    id_valid = 1'($urandom); id_op = 6'($urandom); id_rs = 5'($urandom); id_rt = 5'($urandom);
    id_uses_rs = 1'($urandom); id_uses_rt = 1'($urandom); ex_rd = 5'($urandom);
    ex_we = 1'($urandom); ex_is_load = 1'($urandom); ex_branch_taken = 1'($urandom);
  endtask

  // advance one clock, updating the expected performance counts from the spec rules
  task automatic cyc();
    logic l, h;
    l = id_valid & ex_is_load & ex_we & (ex_rd != 0) &
        ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));
    h = id_valid & (id_op == 6'h3f);
    if (cpu_reset) begin
      mode = 0; dc = 0; ec = 0; es = 0; ef = 0;
    end else begin
      if (mode != 2) ec++;
      if (mode == 0) begin
        if (ex_branch_taken) ef++;
        else if (l) es++;
        else if (h) begin mode = 1; dc = 0; end
      end else if (mode == 1) begin
        if (dc == 2) mode = 2; else dc++;
      end
    end
    @(posedge sysclk); #1;
  endtask

  initial begin
    cpu_reset = 1'b1; rnd(); #3 chk("rst0", 5'b00110);
    cyc(); rnd(); #3 chk("rst1", 5'b00110);
    cyc(); chk_cnt("rst_cnt");
    cpu_reset = 1'b0; idle(); #3 chk("run", 5'b11000);
    cyc(); ex_is_load = 1'b1; ex_we = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
    #3 chk("lu_rs", 5'b00010);
    cyc(); ex_is_load = 1'b0; #3 chk("lu_done", 5'b11000);
    cyc(); idle(); ex_is_load = 1'b1; ex_we = 1'b1; ex_rd = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b1;
    #3 chk("lu_rt", 5'b00010);
    cyc(); idle(); ex_is_load = 1'b1; ex_we = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
    #3 chk("lu_rd0", 5'b11000);
    cyc(); ex_rd = 5'd9; id_rs = 5'd9; ex_we = 1'b0; #3 chk("lu_nowe", 5'b11000);
    cyc(); ex_we = 1'b1; id_valid = 1'b0; #3 chk("lu_invalid", 5'b11000);
    cyc(); id_valid = 1'b1; ex_branch_taken = 1'b1; #3 chk("br_lu", 5'b11110);
    cyc(); idle(); #3 chk_cnt("br_cnt");
    chk("br_after", 5'b11000);
    cyc(); id_op = 6'h3f; ex_branch_taken = 1'b1; #3 chk("hlt_wrongpath", 5'b11110);
    cyc(); idle(); #3 chk("hlt_wp_run", 5'b11000);
    cyc(); id_op = 6'h3f; id_valid = 1'b0; #3 chk("hlt_invalid", 5'b11000);
    cyc(); idle(); id_op = 6'h3f; id_uses_rs = 1'b1; id_rs = 5'd5;
    ex_is_load = 1'b1; ex_we = 1'b1; ex_rd = 5'd5; #3 chk("hlt_stall", 5'b00010);
    cyc(); ex_is_load = 1'b0; #3 chk("hlt_T", 5'b01100);
    cyc(); rnd(); #3 chk("drain_T1", 5'b00110);
    cyc(); rnd(); #3 chk("drain_T2", 5'b00110);
    cyc(); rnd(); #3 chk("drain_T3", 5'b00110);
    cyc(); rnd(); #3 chk("halted_T4", 5'b00111);
    for (int i = 0; i < 12; i++) begin
      cyc(); rnd(); #3 chk("halted_hold", 5'b00111);
    end
    chk_cnt("halt_cnt");
    cpu_reset = 1'b1; #3 chk("rst_halted", 5'b00110);
    cyc(); cpu_reset = 1'b0; idle(); #3 chk("rst_run", 5'b11000);
    chk_cnt("rst_halt_cnt");
    id_op = 6'h3f; #3 chk("hlt2_T", 5'b01100);
    cyc(); idle(); #3 chk("drain2_T1", 5'b00110);
    cyc(); cpu_reset = 1'b1; #3 chk("rst_drain", 5'b00110);
    cyc(); chk_cnt("rst_drain_cnt");
    cpu_reset = 1'b0; idle();
    for (int i = 0; i < 6; i++) begin
      #3 chk("post_rst", 5'b11000);
      cyc();
    end
    chk_cnt("final_cnt");
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
